delay_slot_scheduler: RTL and testbench



---
 rtl/delay_slot_scheduler.sv | 124 ++++++++++++
 tb/tb_delay_slot_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_slot_scheduler.sv
// rtl/delay_slot_scheduler.sv - round-robin scheduler sharing one delay counter among NUM_REQ requesters
// Optional cancel input enabled by defining DELAY_SCHED_CANCEL_EN.

module delay_slot_scheduler #(
   parameter  int NUM_REQ          = 4,
   parameter  int WEIGHT_BIT_WIDTH = 8,
   localparam int ID_W             = $clog2(NUM_REQ)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ*WEIGHT_BIT_WIDTH-1:0] req_delay,
`ifdef DELAY_SCHED_CANCEL_EN
   input  logic                                cancel,
`endif
   output logic [NUM_REQ-1:0]                  req_ready,
   output logic                                busy,
   output logic [ID_W-1:0]                     active_id,
   output logic                                done_valid,
   output logic [ID_W-1:0]                     done_id
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                      state_q;
   logic [WEIGHT_BIT_WIDTH-1:0] cnt_q;
   logic [WEIGHT_BIT_WIDTH-1:0] cnt_d;
   logic [ID_W-1:0]             last_grant_q;
   logic [ID_W-1:0]             active_id_q;
   logic                        done_valid_q;
   logic [ID_W-1:0]             done_id_q;

   logic                        sel_found;
   logic [ID_W-1:0]             sel_idx;
   logic [WEIGHT_BIT_WIDTH-1:0] sel_delay;
   logic                        accept;
   logic                        cancel_w;

`ifdef DELAY_SCHED_CANCEL_EN
   assign cancel_w = cancel;
`else
   assign cancel_w = 1'b0;
`endif

   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
      return ID_W'((int'(base) + k) % NUM_REQ);
   endfunction

   // Scan starts one past the last winner so the previous grantee ranks last.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!sel_found && req_valid[wrap_idx(last_grant_q, k)]) begin
            sel_found = 1'b1;
            sel_idx   = wrap_idx(last_grant_q, k);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && (state_q == S_IDLE) && sel_found) begin
         req_ready[sel_idx] = 1'b1;
      end
   end

   assign accept     = |(req_valid & req_ready);
   assign sel_delay  = req_delay[int'(sel_idx)*WEIGHT_BIT_WIDTH +: WEIGHT_BIT_WIDTH];
   assign cnt_d      = cnt_q - WEIGHT_BIT_WIDTH'(1);

   assign busy       = (state_q != S_IDLE);
   assign active_id  = active_id_q;
   assign done_valid = done_valid_q;
   assign done_id    = done_id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         active_id_q  <= '0;
         done_valid_q <= 1'b0;
         done_id_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  cnt_q        <= sel_delay;
                  active_id_q  <= sel_idx;
                  last_grant_q <= sel_idx;
                  state_q      <= S_COUNT;
               end
            end
            // Cancel takes priority over expiry, even on the terminal count.
            S_COUNT: begin
               if (cancel_w) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == '0) begin
                  state_q      <= S_DONE;
                  done_valid_q <= 1'b1;
                  done_id_q    <= active_id_q;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_DONE: begin
               state_q      <= S_IDLE;
               done_valid_q <= 1'b0;
            end
            default: begin
               state_q      <= S_IDLE;
               done_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_delay_slot_scheduler.sv
// tb/tb_delay_slot_scheduler.sv - directed scoreboard bench for delay_slot_scheduler

module tb_delay_slot_scheduler;
    localparam int NR = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*W-1:0] req_delay = '0;
`ifdef DELAY_SCHED_CANCEL_EN
    logic            cancel = 1'b0;
`endif
    logic [NR-1:0]   req_ready;
    logic            busy;
    logic [1:0]      active_id;
    logic            done_valid;
    logic [1:0]      done_id;

    delay_slot_scheduler #(.NUM_REQ(NR), .WEIGHT_BIT_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_delay  (req_delay),
`ifdef DELAY_SCHED_CANCEL_EN
        .cancel     (cancel),
`endif
        .req_ready  (req_ready),
        .busy       (busy),
        .active_id  (active_id),
        .done_valid (done_valid),
        .done_id    (done_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_id[$];
    int exp_cyc[$];

    task automatic check(input string tag, input logic ok, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_delay(input int i, input int d);
        req_delay[i*W +: W] = W'(d);
    endtask

    task automatic push(input int id, input int c);
        exp_id.push_back(id);
        exp_cyc.push_back(c);
    endtask

    task automatic tick();
        int id;
        int c;
        @(negedge clk);
        if (done_valid) begin
            if (exp_id.size() == 0) begin
                check("done_unexpected", done_valid === 1'b0, done_valid, 1'b0);
            end else begin
                id = exp_id.pop_front();
                c  = exp_cyc.pop_front();
                check("done_id", int'(done_id) === id, done_id, id);
                check("done_cycle", cyc === c, cyc, c);
            end
        end else if (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
            check("done_missing", done_valid === 1'b1, done_valid, 1'b1);
            void'(exp_id.pop_front());
            void'(exp_cyc.pop_front());
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int nbusy);
        logic ok;
        ok    = 1'b0;
        nbusy = 0;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            if (busy) nbusy++;
            if (!busy && exp_id.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", ok === 1'b1, ok, 1'b1);
    endtask

    task automatic run_job(input int id, input int d, output int busy_total);
        int nb;
        req_valid = '0;
        req_valid[id] = 1'b1;
        set_delay(id, d);
        push(id, cyc + 1 + d + 1);
        tick();
        busy_total = busy ? 1 : 0;
        req_valid = '0;
        wait_idle(d + 20, nb);
        busy_total += nb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int c0;
        int more;

        rst_n     = 1'b0;
        req_valid = 4'b0001;
        set_delay(0, 5);
        @(negedge clk);
        @(negedge clk);
        check("reset_req_ready", req_ready === 4'b0000, req_ready, 4'b0000);
        check("reset_busy", busy === 1'b0, busy, 1'b0);
        check("reset_done_valid", done_valid === 1'b0, done_valid, 1'b0);
        check("reset_done_id", done_id === 2'd0, done_id, 2'd0);
        check("reset_active_id", active_id === 2'd0, active_id, 2'd0);

        rst_n = 1'b1;
        #1;
        check("t1_req_ready", req_ready === 4'b0001, req_ready, 4'b0001);
        push(0, cyc + 1 + 5 + 1);
        tick();
        check("t1_active_id", active_id === 2'd0, active_id, 2'd0);
        check("t1_ready_low_in_count", req_ready === 4'b0000, req_ready, 4'b0000);
        nb = busy ? 1 : 0;
        req_valid = '0;
        wait_idle(30, more);
        nb += more;
        check("t1_busy_cycles", nb === 7, nb, 7);

        req_valid = 4'b1000;
        set_delay(3, 4);
        push(3, cyc + 1 + 4 + 1);
        tick();
        check("t2_active_id", active_id === 2'd3, active_id, 2'd3);
        set_delay(3, 50);
        req_valid = '0;
        wait_idle(80, nb);

        run_job(1, 255, nb);
        check("t2_max_delay_busy", nb === 257, nb, 257);

        run_job(2, 0, nb);
        check("t2_zero_delay_busy", nb === 2, nb, 2);

        req_valid = 4'b0010;
        set_delay(1, 10);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("t3_busy_before_reset", busy === 1'b1, busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t3_reset_busy", busy === 1'b0, busy, 1'b0);
        check("t3_reset_active_id", active_id === 2'd0, active_id, 2'd0);
        check("t3_reset_done_valid", done_valid === 1'b0, done_valid, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (15) tick();
        check("t3_idle_after_reset", busy === 1'b0, busy, 1'b0);

        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) set_delay(i, 0);
        c0 = cyc;
        for (int k = 0; k < 5; k++) push(k % NR, c0 + 2 + 3*k);
        tick();
        check("t4_first_grant", active_id === 2'd0, active_id, 2'd0);
        repeat (12) tick();
        req_valid = '0;
        wait_idle(20, nb);

        req_valid = 4'b0001;
        set_delay(0, 3);
        push(0, cyc + 1 + 3 + 1);
        tick();
        req_valid = 4'b0101;
        tick();
        tick();
        req_valid = 4'b0000;
        wait_idle(20, nb);
        check("t5_ready_idle_none", req_ready === 4'b0000, req_ready, 4'b0000);
        req_valid = 4'b0110;
        set_delay(1, 2);
        set_delay(2, 7);
        #1;
        check("t5_rr_after_0", req_ready === 4'b0010, req_ready, 4'b0010);
        push(1, cyc + 1 + 2 + 1);
        tick();
        req_valid = '0;
        wait_idle(20, nb);

`ifdef DELAY_SCHED_CANCEL_EN
        req_valid = 4'b0101;
        set_delay(2, 10);
        set_delay(0, 1);
        #1;
        check("c1_ready", req_ready === 4'b0100, req_ready, 4'b0100);
        tick();
        req_valid = 4'b0001;
        repeat (7) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("c1_busy_after_cancel", busy === 1'b0, busy, 1'b0);
        check("c1_next_ready", req_ready === 4'b0001, req_ready, 4'b0001);
        push(0, cyc + 1 + 1 + 1);
        tick();
        req_valid = '0;
        wait_idle(20, nb);

        req_valid = 4'b1000;
        set_delay(3, 2);
        tick();
        req_valid = '0;
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("c2_busy_after_cancel", busy === 1'b0, busy, 1'b0);
        repeat (5) tick();
`endif

        check("scoreboard_drained", exp_id.size() === 0, exp_id.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
